// File: rtl/alu_result_accumulator.sv
// Collects LEN signed 17-bit ALU results into a wide accumulator and emits one
// saturated window sum per window, together with sample and carry counts.
module alu_result_accumulator #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned OUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [16:0]                in_y,
  input  logic                       in_co,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_sat,
  output logic [$clog2(LEN+1)-1:0]   out_count,
  output logic [$clog2(LEN+1)-1:0]   out_co_cnt,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned CW = $clog2(LEN + 1);

  localparam logic signed [ACC_W-1:0] MaxVal = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinVal = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [CW-1:0]           co_q, co_n;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [CW-1:0]           out_count_q;
  logic [CW-1:0]           out_co_cnt_q;

  logic                    accept;
  logic                    close;
  logic                    sat_hi, sat_lo;
  logic signed [ACC_W-1:0] y_ext;

  assign in_ready = (state_q == StAcc) | out_ready;
  assign accept   = in_valid & in_ready;
  assign y_ext    = {{(ACC_W-17){in_y[16]}}, in_y};

  always_comb begin
    acc_n = acc_q;
    cnt_n = cnt_q;
    co_n  = co_q;
    if (accept) begin
      acc_n = acc_q + y_ext;
      cnt_n = cnt_q + CW'(1);
      co_n  = co_q + CW'(in_co);
    end
  end

  // A same-cycle sample is folded in before flush is evaluated.
  assign close = (accept && (cnt_q == CW'(LEN - 1))) ||
                 (flush && (state_q == StAcc) && (cnt_n != '0));

  always_comb begin
    sat_hi     = acc_n > MaxVal;
    sat_lo     = acc_n < MinVal;
    out_sat_d  = sat_hi | sat_lo;
    out_data_d = acc_n[OUT_W-1:0];
    if (sat_hi) begin
      out_data_d = MaxVal[OUT_W-1:0];
    end else if (sat_lo) begin
      out_data_d = MinVal[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    if (close) begin
      state_d = StHold;
    end else if ((state_q == StHold) && out_ready) begin
      state_d = StAcc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAcc;
      acc_q        <= '0;
      cnt_q        <= '0;
      co_q         <= '0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      out_count_q  <= '0;
      out_co_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (close) begin
        acc_q        <= '0;
        cnt_q        <= '0;
        co_q         <= '0;
        out_data_q   <= out_data_d;
        out_sat_q    <= out_sat_d;
        out_count_q  <= cnt_n;
        out_co_cnt_q <= co_n;
      end else begin
        acc_q <= acc_n;
        cnt_q <= cnt_n;
        co_q  <= co_n;
      end
    end
  end

  assign out_valid  = (state_q == StHold);
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign out_count  = out_count_q;
  assign out_co_cnt = out_co_cnt_q;

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Scoreboard bench: stimulus pushes hand-computed window results, a monitor
// pops and compares them at every result handoff.
module tb_alu_result_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] in_y;
  logic        in_co;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] out_data;
  logic        out_sat;
  logic [2:0]  out_count;
  logic [2:0]  out_co_cnt;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    logic [2:0]  cnt;
    logic [2:0]  co;
  } exp_t;

  exp_t exp_q[$];

  alu_result_accumulator #(.LEN(4), .ACC_W(24), .OUT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_y       (in_y),
    .in_co      (in_co),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_count  (out_count),
    .out_co_cnt (out_co_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Monitor: every handoff must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL handoff_unexpected: got data=%0d count=%0d, required no result",
                 $signed(out_data), out_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_sat !== e.sat || out_count !== e.cnt ||
            out_co_cnt !== e.co) begin
          failures++;
          $display("FAIL handoff: got data=%0d sat=%0b count=%0d co=%0d, required data=%0d sat=%0b count=%0d co=%0d",
                   $signed(out_data), out_sat, out_count, out_co_cnt,
                   $signed(e.data), e.sat, e.cnt, e.co);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic s, input logic [2:0] c,
                      input logic [2:0] co);
    exp_t e;
    e.data = d; e.sat = s; e.cnt = c; e.co = co;
    exp_q.push_back(e);
  endtask

  // Called and returns at posedge+1; holds the sample until it is accepted.
  task automatic send(input logic [16:0] y, input logic co, input logic fl);
    bit done;
    done     = 1'b0;
    in_y     = y;
    in_co    = co;
    in_valid = 1'b1;
    flush    = fl;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    int vcnt;
    rst = 1'b1; in_y = '0; in_co = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_count", 32'(out_count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // T1: 100 - 50 - 1 + 7 = 56, two carries
    push(16'd56, 1'b0, 3'd4, 3'd2);
    send(17'd100, 1'b0, 1'b0);
    send(17'h1FFCE, 1'b1, 1'b0);
    send(17'h1FFFF, 1'b1, 1'b0);
    send(17'd7, 1'b0, 1'b0);
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("t1_valid_cycles", 32'(vcnt), 32'd1);
    @(posedge clk);
    #1;

    // T2: 4 * 65534 saturates high
    push(16'd32767, 1'b1, 3'd4, 3'd0);
    repeat (4) send(17'h0FFFE, 1'b0, 1'b0);
    // T3: 4 * -65536 saturates low
    push(16'h8000, 1'b1, 3'd4, 3'd0);
    repeat (4) send(17'h10000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // T4: backpressure with a waiting sample
    out_ready = 1'b0;
    push(16'd10, 1'b0, 3'd4, 3'd0);
    send(17'd1, 1'b0, 1'b0);
    send(17'd2, 1'b0, 1'b0);
    send(17'd3, 1'b0, 1'b0);
    send(17'd4, 1'b0, 1'b0);
    in_valid = 1'b1; in_y = 17'd5;
    repeat (5) begin
      @(negedge clk);
      check("t4_in_ready", 32'(in_ready), 32'd0);
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_data", 32'(out_data), 32'd10);
      check("t4_count", 32'(out_count), 32'd4);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(16'd26, 1'b0, 3'd4, 3'd0);
    send(17'd5, 1'b0, 1'b0);
    send(17'd6, 1'b0, 1'b0);
    send(17'd7, 1'b0, 1'b0);
    send(17'd8, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // T5: flush alone, flush with a sample, flush on an empty window
    push(16'd30, 1'b0, 3'd2, 3'd0);
    send(17'd10, 1'b0, 1'b0);
    send(17'd20, 1'b0, 1'b0);
    pulse_flush();
    @(posedge clk);
    #1;
    push(16'd5, 1'b0, 3'd1, 3'd1);
    send(17'd5, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    pulse_flush();
    repeat (4) begin
      @(negedge clk);
      check("t5_empty_flush_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // T6: reset discards a partial window
    repeat (3) send(17'd1000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    push(16'd4, 1'b0, 3'd4, 3'd0);
    repeat (4) send(17'd1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
